data_memory_stage: RTL and testbench

- Memory-access stage of the sequential 64-bit RISC-V core, directly upstream of write-back.
- Takes the ALU-computed address and store data, and performs doubleword loads (ld) and stores (sd) on an internal byte-addressed, little-endian data memory with configurable access latency.
- Presents the loaded doubleword on read_data, which feeds the write-back mux.
- Exposes a start/busy/done handshake so the sequential controller holds the PC until the access completes.

---
 rtl/data_memory_stage.sv | 98 +++++++++
 tb/tb_data_memory_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// Memory-access stage: aligned doubleword ld/sd on an internal little-endian RAM with a start/busy/done handshake.
// Optional MEM_DEBUG_EN prints each commit and each rejected request.
module data_memory_stage #(
  parameter int unsigned MEM_BYTES      = 1024,
  parameter int unsigned ACCESS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [63:0] address,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        busy,
  output logic        done,
  output logic        mem_err
);

  localparam int unsigned WORDS = MEM_BYTES / 8;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx;
  logic [63:0]      wdata;
  logic             is_write;
  logic [3:0]       count;
  logic             no_op, legal, accept, reject, commit;

  // Accesses are always doubleword aligned, so the array holds whole words;
  // byte 8k+i lives in bits [8i+7:8i] of word k (little-endian).
  logic [63:0] mem [WORDS] = '{default: '0};

  always_comb begin
    no_op  = !mem_read && !mem_write;
    legal  = (mem_read ^ mem_write) && (address[2:0] == 3'b000)
             && (address < 64'(MEM_BYTES));
    accept = (state == IDLE) && start && legal;
    reject = (state == IDLE) && start && !no_op && !legal;
    commit = (state == WAIT) && (count == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = legal ? WAIT : DONE;
      WAIT:    if (count == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      count     <= '0;
      mem_err   <= 1'b0;
      idx       <= '0;
      wdata     <= '0;
      is_write  <= 1'b0;
    end else begin
      // Only set on the IDLE->DONE rejection path, so it reads 0 outside DONE.
      mem_err <= reject;
      if (accept) begin
        idx      <= address[3 +: IDX_W];
        wdata    <= write_data;
        is_write <= mem_write;
        count    <= 4'(ACCESS_LATENCY - 1);
      end else if ((state == WAIT) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (commit && !is_write) read_data <= mem[idx];
`ifdef MEM_DEBUG_EN
      if (commit && is_write)
        $display("Mem Stage: Store addr=%0d data=%0d", {idx, 3'b000}, wdata);
      if (commit && !is_write)
        $display("Mem Stage: Load addr=%0d data=%0d", {idx, 3'b000}, mem[idx]);
      if (reject)
        $display("Mem Stage: Error addr=%0d", address);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && is_write) mem[idx] <= wdata;
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_data_memory_stage.sv
// Directed bench for data_memory_stage: default latency-2 instance plus latency-1 and latency-15 instances.
module tb_data_memory_stage;

  logic        clk = 1'b0;
  logic        rst, start, mem_read, mem_write;
  logic [63:0] address, write_data;
  logic [63:0] read_data, read_data_l1, read_data_l15;
  logic        busy, done, mem_err;
  logic        busy_l1, done_l1, mem_err_l1, busy_l15, done_l15, mem_err_l15;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  data_memory_stage #(.MEM_BYTES(1024), .ACCESS_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .busy(busy), .done(done), .mem_err(mem_err));

  data_memory_stage #(.MEM_BYTES(1024), .ACCESS_LATENCY(1)) dut_l1 (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data_l1),
    .busy(busy_l1), .done(done_l1), .mem_err(mem_err_l1));

  data_memory_stage #(.MEM_BYTES(1024), .ACCESS_LATENCY(15)) dut_l15 (
    .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data_l15),
    .busy(busy_l15), .done(done_l15), .mem_err(mem_err_l15));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start pulse; returns just after the sampling edge.
  task automatic issue(input logic r, input logic w, input logic [63:0] a, input logic [63:0] d);
    start = 1'b1; mem_read = r; mem_write = w; address = a; write_data = d;
    tick();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    address = 64'h0; write_data = 64'h0;
  endtask

  // n = edges from the start-sampling edge up to the one after which done is seen.
  task automatic wait_done(output int n, output logic err);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    err = mem_err;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    address = 64'h0; write_data = 64'h0;
    tick(); tick();
    rst = 1'b0;
    nvec++; if (read_data !== 64'h0) begin $display("FAIL reset_read_data got %h want 0", read_data); nfail++; end
    nvec++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); nfail++; end
    nvec++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); nfail++; end
    nvec++; if (mem_err !== 1'b0) begin $display("FAIL reset_mem_err got %b want 0", mem_err); nfail++; end
  endtask

  task automatic test_store_load();
    int n; logic err;
    issue(1'b0, 1'b1, 64'd16, 64'h1122334455667788);
    nvec++; if (busy !== 1'b1) begin $display("FAIL sd_busy got %b want 1", busy); nfail++; end
    wait_done(n, err);
    nvec++; if (n !== 3) begin $display("FAIL sd_latency got %0d want 3", n); nfail++; end
    nvec++; if (err !== 1'b0) begin $display("FAIL sd_mem_err got %b want 0", err); nfail++; end
    tick();
    nvec++; if (done !== 1'b0 || busy !== 1'b0) begin $display("FAIL sd_after got done=%b busy=%b want 0 0", done, busy); nfail++; end
    issue(1'b1, 1'b0, 64'd16, 64'h0);
    wait_done(n, err);
    nvec++; if (n !== 3) begin $display("FAIL ld_latency got %0d want 3", n); nfail++; end
    nvec++; if (read_data !== 64'h1122334455667788) begin $display("FAIL ld_data got %h want 1122334455667788", read_data); nfail++; end
    nvec++; if (read_data[7:0] !== 8'h88) begin $display("FAIL ld_byte16 got %h want 88", read_data[7:0]); nfail++; end
    nvec++; if (read_data[63:56] !== 8'h11) begin $display("FAIL ld_byte23 got %h want 11", read_data[63:56]); nfail++; end
    tick();
  endtask

  task automatic test_passthrough();
    int n; logic err;
    issue(1'b0, 1'b0, 64'd40, 64'hDEAD);
    wait_done(n, err);
    nvec++; if (n !== 1) begin $display("FAIL pass_latency got %0d want 1", n); nfail++; end
    nvec++; if (err !== 1'b0) begin $display("FAIL pass_mem_err got %b want 0", err); nfail++; end
    nvec++; if (busy !== 1'b1) begin $display("FAIL pass_busy got %b want 1", busy); nfail++; end
    nvec++; if (read_data !== 64'h1122334455667788) begin $display("FAIL pass_read_data got %h want 1122334455667788", read_data); nfail++; end
    tick();
    nvec++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL pass_after got busy=%b done=%b want 0 0", busy, done); nfail++; end
  endtask

  task automatic test_errors();
    logic        rv [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        wv [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [63:0] av [4] = '{64'd12, 64'd1024, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8};
    int n; logic err;
    for (int i = 0; i < 4; i++) begin
      issue(rv[i], wv[i], av[i], 64'hA5A5_A5A5_A5A5_A5A5);
      wait_done(n, err);
      nvec++; if (n !== 1) begin $display("FAIL err%0d_latency got %0d want 1", i, n); nfail++; end
      nvec++; if (err !== 1'b1) begin $display("FAIL err%0d_mem_err got %b want 1", i, err); nfail++; end
      nvec++; if (read_data !== 64'h1122334455667788) begin $display("FAIL err%0d_read_data got %h want 1122334455667788", i, read_data); nfail++; end
      tick();
      nvec++; if (mem_err !== 1'b0) begin $display("FAIL err%0d_mem_err_after got %b want 0", i, mem_err); nfail++; end
    end
    issue(1'b1, 1'b0, 64'd0, 64'h0);
    wait_done(n, err);
    nvec++; if (read_data !== 64'h0) begin $display("FAIL err_mem0 got %h want 0", read_data); nfail++; end
    tick();
  endtask

  task automatic test_ignore_start();
    int n; int dones; int first; logic err;
    issue(1'b0, 1'b1, 64'd24, 64'hCAFE_F00D_0000_0001);
    issue(1'b0, 1'b1, 64'd32, 64'hBBBB_BBBB_BBBB_BBBB);
    dones = 0; first = 0;
    for (int c = 3; c <= 12; c++) begin
      if (done === 1'b1) begin
        dones++;
        if (first == 0) first = c - 1;
      end
      tick();
    end
    nvec++; if (dones !== 1) begin $display("FAIL ignore_done_count got %0d want 1", dones); nfail++; end
    nvec++; if (first !== 3) begin $display("FAIL ignore_latency got %0d want 3", first); nfail++; end
    issue(1'b1, 1'b0, 64'd32, 64'h0);
    wait_done(n, err);
    nvec++; if (read_data !== 64'h0) begin $display("FAIL ignore_addr32 got %h want 0", read_data); nfail++; end
    tick();
    issue(1'b1, 1'b0, 64'd24, 64'h0);
    wait_done(n, err);
    nvec++; if (read_data !== 64'hCAFE_F00D_0000_0001) begin $display("FAIL ignore_addr24 got %h want cafef00d00000001", read_data); nfail++; end
    tick();
  endtask

  task automatic test_reset_mid();
    int n; logic err;
    issue(1'b0, 1'b1, 64'd8, 64'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    nvec++; if (busy !== 1'b0) begin $display("FAIL rstmid_busy got %b want 0", busy); nfail++; end
    nvec++; if (read_data !== 64'h0) begin $display("FAIL rstmid_read_data got %h want 0", read_data); nfail++; end
    nvec++; if (done !== 1'b0) begin $display("FAIL rstmid_done got %b want 0", done); nfail++; end
    issue(1'b1, 1'b0, 64'd8, 64'h0);
    wait_done(n, err);
    nvec++; if (n !== 3) begin $display("FAIL rstmid_ld_latency got %0d want 3", n); nfail++; end
    nvec++; if (read_data !== 64'h0) begin $display("FAIL rstmid_ld_data got %h want 0", read_data); nfail++; end
    tick();
  endtask

  task automatic test_latency();
    int n1; int n2; int n15;
    for (int c = 0; c < 20; c++) tick();
    nvec++; if (busy_l15 !== 1'b0) begin $display("FAIL lat_l15_idle got busy=%b want 0", busy_l15); nfail++; end
    issue(1'b1, 1'b0, 64'd16, 64'h0);
    n1 = 0; n2 = 0; n15 = 0;
    for (int c = 1; c <= 30; c++) begin
      if (done_l1 === 1'b1 && n1 == 0) n1 = c;
      if (done === 1'b1 && n2 == 0) n2 = c;
      if (done_l15 === 1'b1 && n15 == 0) n15 = c;
      tick();
    end
    nvec++; if (n1 !== 2) begin $display("FAIL lat1 got %0d want 2", n1); nfail++; end
    nvec++; if (n2 !== 3) begin $display("FAIL lat2 got %0d want 3", n2); nfail++; end
    nvec++; if (n15 !== 16) begin $display("FAIL lat15 got %0d want 16", n15); nfail++; end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_passthrough();
    test_errors();
    test_ignore_start();
    test_reset_mid();
    test_latency();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
